// File: rtl/demux4output_pkg.sv
// Shared types for the registered 1-to-4 demultiplexer.
// DEMUX4OUTPUT_SKID_EN selects the 2-entry slot state encoding.
package demux4output_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic [1:0] {
        CH0 = 2'b00,
        CH1 = 2'b01,
        CH2 = 2'b10,
        CH3 = 2'b11
    } ch_sel_t;

`ifdef DEMUX4OUTPUT_SKID_EN
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } slot_state_t;
`else
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;
`endif

endpackage

// File: rtl/demux4output_slot.sv
// One destination channel buffer: 1 entry by default, 2-entry FIFO when
// DEMUX4OUTPUT_SKID_EN is defined. Output always shows the oldest word.
module demux4output_slot
    import demux4output_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             rd_ready_i,
    output logic             full_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    slot_state_t      state_q;
    logic [WIDTH-1:0] head_q;
    logic             drain;

    assign drain = (state_q != EMPTY) && rd_ready_i;

`ifdef DEMUX4OUTPUT_SKID_EN
    logic [WIDTH-1:0] tail_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (wr_en_i) begin
                        head_q  <= data_i;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (wr_en_i && drain) begin
                        head_q <= data_i;
                    end else if (wr_en_i) begin
                        tail_q  <= data_i;
                        state_q <= TWO;
                    end else if (drain) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    // No write can arrive here: the top holds ready low while TWO.
                    if (drain) begin
                        head_q <= tail_q;
                        if (wr_en_i) begin
                            tail_q <= data_i;
                        end else begin
                            state_q <= ONE;
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign full_o = (state_q == TWO);
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            head_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (wr_en_i) begin
                        head_q  <= data_i;
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    // A write while FULL implies a same-cycle drain: replace in place.
                    if (wr_en_i) begin
                        head_q <= data_i;
                    end else if (drain) begin
                        state_q <= EMPTY;
                    end
                end
            endcase
        end
    end

    assign full_o = (state_q == FULL);
`endif

    assign valid_o = (state_q != EMPTY);
    assign data_o  = head_q;

endmodule

// File: rtl/demux4output.sv
// Registered 1-to-4 demultiplexer with valid/ready on both sides.
// Define DEMUX4OUTPUT_SKID_EN for 2-entry slots and a registered-only ready_o.
module demux4output
    import demux4output_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [1:0]        select_i,
    input  logic [WIDTH-1:0]  data_i,
    output logic              ready_o,
    output logic [WIDTH-1:0]  output_0_o,
    output logic [WIDTH-1:0]  output_1_o,
    output logic [WIDTH-1:0]  output_2_o,
    output logic [WIDTH-1:0]  output_3_o,
    output logic [NUM_CH-1:0] valid_o,
    input  logic [NUM_CH-1:0] ready_i
);

    ch_sel_t          sel;
    logic             accept;
    logic [NUM_CH-1:0] wr_en;
    logic [NUM_CH-1:0] full;
    logic [WIDTH-1:0] slot_data [NUM_CH];

    assign sel = ch_sel_t'(select_i);

`ifdef DEMUX4OUTPUT_SKID_EN
    assign ready_o = ~full[sel];
`else
    // A full slot can still take a word if its sink drains it this same cycle.
    assign ready_o = ~full[sel] | ready_i[sel];
`endif

    assign accept = valid_i & ready_o;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_slot
        assign wr_en[n] = accept && (select_i == 2'(n));

        demux4output_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .wr_en_i    (wr_en[n]),
            .data_i     (data_i),
            .rd_ready_i (ready_i[n]),
            .full_o     (full[n]),
            .valid_o    (valid_o[n]),
            .data_o     (slot_data[n])
        );
    end

    assign output_0_o = slot_data[0];
    assign output_1_o = slot_data[1];
    assign output_2_o = slot_data[2];
    assign output_3_o = slot_data[3];

endmodule

// File: tb/tb_demux4output.sv
// Scoreboard bench for demux4output: per-channel expected queues are filled on
// accept and drained on sink handshake; works for either slot depth.
module tb_demux4output;

    localparam int WIDTH = 32;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             valid_i;
    logic [1:0]       select_i;
    logic [WIDTH-1:0] data_i;
    logic             ready_o;
    logic [WIDTH-1:0] output_0_o, output_1_o, output_2_o, output_3_o;
    logic [3:0]       valid_o;
    logic [3:0]       ready_i;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q0[$], q1[$], q2[$], q3[$];

    demux4output #(.WIDTH(WIDTH)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .select_i   (select_i),
        .data_i     (data_i),
        .ready_o    (ready_o),
        .output_0_o (output_0_o),
        .output_1_o (output_1_o),
        .output_2_o (output_2_o),
        .output_3_o (output_3_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [WIDTH-1:0] got,
                             input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int qsize(input int n);
        case (n)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] qfront(input int n);
        case (n)
            0: return q0[0];
            1: return q1[0];
            2: return q2[0];
            default: return q3[0];
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] dut_out(input int n);
        case (n)
            0: return output_0_o;
            1: return output_1_o;
            2: return output_2_o;
            default: return output_3_o;
        endcase
    endfunction

    task automatic qpop(input int n);
        case (n)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            2: void'(q2.pop_front());
            default: void'(q3.pop_front());
        endcase
    endtask

    task automatic qpush(input int n, input logic [WIDTH-1:0] d);
        case (n)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    // One clock: drive after negedge, compare and update model before the posedge.
    task automatic cycle(input logic v, input logic [1:0] sel, input logic [WIDTH-1:0] d,
                         input logic [3:0] rdy, input logic rst, output logic acc);
        logic exp_rdy;
        @(negedge clk_i);
        valid_i  = v;
        select_i = sel;
        data_i   = d;
        ready_i  = rdy;
        rst_i    = rst;
        #2;
        for (int n = 0; n < 4; n++) begin
            check_val($sformatf("valid%0d", n), {31'b0, valid_o[n]}, {31'b0, qsize(n) != 0});
            if (qsize(n) != 0) check_val($sformatf("data%0d", n), dut_out(n), qfront(n));
        end
`ifdef DEMUX4OUTPUT_SKID_EN
        exp_rdy = (qsize(int'(sel)) < 2);
`else
        exp_rdy = (qsize(int'(sel)) == 0) || rdy[sel];
`endif
        check_val("ready_o", {31'b0, ready_o}, {31'b0, exp_rdy});
        acc = v && exp_rdy && !rst;
        if (rst) begin
            q0.delete(); q1.delete(); q2.delete(); q3.delete();
        end else begin
            for (int n = 0; n < 4; n++)
                if (qsize(n) != 0 && rdy[n]) qpop(n);
            if (acc) qpush(int'(sel), d);
        end
    endtask

    task automatic send(input logic [1:0] sel, input logic [WIDTH-1:0] d,
                        input logic [3:0] rdy, output int cyc);
        logic acc;
        acc = 1'b0;
        cyc = 0;
        while (!acc && cyc < 20) begin
            cycle(1'b1, sel, d, rdy, 1'b0, acc);
            cyc++;
        end
        if (!acc) check_val("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input logic [3:0] rdy, input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, '0, rdy, 1'b0, acc);
    endtask

    initial begin
        logic acc;
        int   cyc;

        // Bring state out of X before the model starts comparing.
        rst_i = 1'b1; valid_i = 1'b1; select_i = 2'b00; data_i = 32'hDEAD_BEEF; ready_i = 4'b0000;
        @(posedge clk_i);

        // Reset held two cycles with valid high: nothing may be accepted.
        cycle(1'b1, 2'b00, 32'hDEAD_BEEF, 4'b0000, 1'b1, acc);
        cycle(1'b1, 2'b01, 32'hDEAD_BEEF, 4'b0000, 1'b1, acc);
        @(negedge clk_i);
        check_val("rst_valid", {28'b0, valid_o}, 32'd0);
        check_val("rst_out0", output_0_o, 32'd0);
        check_val("rst_out1", output_1_o, 32'd0);
        check_val("rst_out2", output_2_o, 32'd0);
        check_val("rst_out3", output_3_o, 32'd0);

        send(2'b00, 32'h1234_5678, 4'b1111, cyc);
        check_val("first_accept_cycles", cyc, 32'd1);

        // Basic routing, one word per channel back to back.
        send(2'b00, 32'hAAAA_0000, 4'b1111, cyc);
        send(2'b01, 32'hBBBB_0001, 4'b1111, cyc);
        send(2'b10, 32'hCCCC_0002, 4'b1111, cyc);
        send(2'b11, 32'hDDDD_0003, 4'b1111, cyc);
        idle(4'b1111, 2);

        // Backpressure on ch2.
        send(2'b10, 32'h0000_0011, 4'b1011, cyc);
        cycle(1'b1, 2'b10, 32'h0000_0022, 4'b1011, 1'b0, acc);
`ifdef DEMUX4OUTPUT_SKID_EN
        check_val("skid_second_acc", {31'b0, acc}, 32'd1);
        cycle(1'b1, 2'b10, 32'h0000_0033, 4'b1011, 1'b0, acc);
        check_val("skid_third_acc", {31'b0, acc}, 32'd0);
        send(2'b10, 32'h0000_0033, 4'b1111, cyc);
`else
        check_val("bp_second_acc", {31'b0, acc}, 32'd0);
        send(2'b10, 32'h0000_0022, 4'b1111, cyc);
        check_val("bp_release_cycles", cyc, 32'd1);
`endif
        idle(4'b1111, 3);

        // Blocked ch1 must not block ch3.
        send(2'b01, 32'h0000_00A1, 4'b1101, cyc);
        send(2'b11, 32'h0000_0005, 4'b0101, cyc);
        check_val("ch3_immediate", cyc, 32'd1);
        @(negedge clk_i);
        check_val("blocked_valid", {28'b0, valid_o}, 32'h0000_000A);
        ready_i = 4'b0101;
        idle(4'b1111, 3);

        // Full-rate streaming on ch0.
        for (int i = 0; i < 16; i++) begin
            send(2'b00, 32'h1000_0000 + 32'(i), 4'b1111, cyc);
            check_val($sformatf("stream_gap%0d", i), cyc, 32'd1);
        end
        idle(4'b1111, 2);

        // Reset with ch0 and ch3 holding words.
        send(2'b00, 32'h0000_00F0, 4'b0110, cyc);
        send(2'b11, 32'h0000_00F3, 4'b0110, cyc);
        cycle(1'b1, 2'b01, 32'h0000_0BAD, 4'b0110, 1'b1, acc);
        @(negedge clk_i);
        check_val("midrst_valid", {28'b0, valid_o}, 32'd0);
        check_val("midrst_out0", output_0_o, 32'd0);
        check_val("midrst_out3", output_3_o, 32'd0);
        send(2'b01, 32'h0000_0077, 4'b1111, cyc);
        check_val("resume_cycles", cyc, 32'd1);
        idle(4'b1111, 3);

        check_val("sb_empty", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux4output.md
Name: demux4output

Overview:
- Registered 1-to-4 demultiplexer: the write-side counterpart of the 4-input select mux.
- Takes one source stream (data plus 2-bit destination select) and routes each accepted word to exactly one of four destination channels.
- Uses valid/ready handshakes on both sides and a per-channel output buffer.
- Sits between a single producer (e.g. LSU store path) and four sinks (e.g. memory, LED, seven-seg, LCD register blocks).

Parameters:
- WIDTH, 32, data word width in bits (matches the codebase vector range).
- NUM_CH, 4, number of destination channels; fixed at 4, with select width 2.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- valid_i  in  1  source word valid.
- select_i  in  2  destination channel for the current word (00→ch0 … 11→ch3).
- data_i  in  WIDTH  source word.
- ready_o  out  1  word accepted this cycle when valid_i && ready_o.
- output_0_o .. output_3_o  out  WIDTH each  channel data.
- valid_o  out  4  per-channel data valid; bit n belongs to output_n_o.
- ready_i  in  4  per-channel sink ready; bit n belongs to output_n_o.

Behaviour:
- Reset (rst_i=1 at clock edge):
  - all slots empty; valid_o=4'b0000.
  - output_0_o..output_3_o=0.
  - in-flight words are discarded.
  - reset dominates any same-cycle handshake.
- Per-channel slot state machine, states EMPTY and FULL (1-entry buffer when the optional feature is off):
  - EMPTY→FULL on accept with select_i==n.
  - FULL→EMPTY on valid_o[n] && ready_i[n] with no new accept for n.
  - FULL→FULL (data replaced) on drain and accept for n in the same cycle.
- ready_o = ~full[select_i] | ready_i[select_i]. This is a combinational path ready_i → ready_o, valid only when select_i is stable while valid_i is high.
- Latency: a word accepted at edge k appears on output_n_o with valid_o[n]=1 in the cycle after edge k. Throughput is 1 word/cycle per channel when the sink holds ready_i high.
- output_n_o holds its value while valid_o[n]=0; data is only loaded on accept. There is no zeroing after drain.
- Only the selected channel changes on an accept. Other channels drain independently in the same cycle.
- select_i is ignored when valid_i=0. ready_o is still driven from the select_i value presented.
- Source protocol: once valid_i=1, the source holds valid_i, select_i and data_i until accepted. The block does not check this.
- Channels never reorder. Words to the same channel exit in acceptance order; no ordering guarantee across channels.

Optional Feature:
- Macro DEMUX4OUTPUT_SKID_EN.
- Defined:
  - each channel slot becomes a 2-entry FIFO with states EMPTY, ONE, TWO.
  - ready_o = ~(count[select_i]==2), registered state only, with no combinational path from ready_i.
  - output shows the head entry; order is preserved.
  - accept and drain in the same cycle in state ONE or TWO leave the count unchanged.
  - accept in state TWO is impossible.
- Undefined: 1-entry behaviour above.
- Latency of 1 cycle is identical in both builds.

Decomposition:
- Package demux4output_pkg:
  - typedef ch_sel_t as a 2-bit enum CH0=2'b00, CH1=2'b01, CH2=2'b10, CH3=2'b11, consistent with the DATA_00..DATA_11 encodings.
  - localparam NUM_CH=4.
  - slot state enum (EMPTY/FULL, or EMPTY/ONE/TWO).
- Sub-module demux4output_slot: one channel buffer with wr_en, data, rd_ready in, and full, valid, data out; instantiated 4× via generate.
- Top level: select decode, ready_o mux, port fan-out.

Test Plan:
- Reset: drive rst_i=1 for 2 cycles with valid_i=1 → valid_o=0000, all outputs 0, no accept recorded; first accept after rst_i=0 succeeds.
- Basic routing: send 0xAAAA0000 sel=00, 0xBBBB0001 sel=01, 0xCCCC0002 sel=10, 0xDDDD0003 sel=11 on consecutive cycles with ready_i=1111 → each word appears on its own channel exactly 1 cycle after acceptance; no other channel asserts valid.
- Backpressure: ready_i[2]=0, send 0x11 then 0x22 to ch2 → first accepted, ready_o=0 for the second (1-entry build). Raise ready_i[2] → 0x11 drains and 0x22 is accepted the same cycle, visible next cycle. Skid build: both accepted, ready_o drops on a third.
- Blocked channel does not block others: ch1 full with ready_i[1]=0; send 0x5 to ch3 → accepted immediately, valid_o=1010.
- Full-rate streaming: 16 consecutive words to ch0 with ready_i[0]=1 → ready_o stays 1 throughout, 16 outputs in order with no gaps.
- Reset mid-operation: ch0 and ch3 full, assert rst_i for one cycle → valid_o=0000 next cycle, buffered words lost, normal operation resumes.
